// File: rtl/spi_cmd_pkg.sv
// -----------------------------------------------------------------------------
// spi_cmd_pkg
// Shared definitions for the SPI command controller: FSM state encoding,
// command byte bit positions and the number of bytes in one register word.
// -----------------------------------------------------------------------------
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RDATA   = 3'd3,
        ST_DISCARD = 3'd4
    } state_e;

    // Command byte layout: bit 7 selects write (1) or read (0), bits 6:0 address.
    localparam int WR_BIT     = 7;
    localparam int ADDR_MSB   = 6;

    // Bytes per 32-bit register word, sent MSB first.
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// spi_cmd_ctrl
// Byte-level command decoder sitting between an SPI byte shifter and a
// register bank. The first byte of each frame is a command (bit 7 = write,
// bits 6:0 = register address); it is followed by 32-bit data words sent
// MSB first. Writes pulse reg_wr_en once per complete word; reads latch the
// addressed register and present its bytes on tx_byte.
//
// Build option:
//   SPI_CMD_AUTOINC_EN  - after each complete word, step reg_addr and keep
//                         the burst going. Without it, bytes after the first
//                         word are ignored.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   ssel_active  high while chip-select is asserted (already synchronised)
//   rx_valid     one-cycle strobe, rx_byte holds a received byte
//   rx_byte      received byte
//   tx_byte      byte to be shifted out on the next transfer
//   reg_wr_en    one-cycle register write strobe
//   reg_addr     register address for reads and writes
//   reg_wr_data  write data, valid with reg_wr_en
//   reg_rd_data  combinational read data for reg_addr
//   cmd_err      sticky bad-address flag, cleared when the next frame starts
// -----------------------------------------------------------------------------
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ssel_active,
    input  logic          rx_valid,
    input  logic [7:0]    rx_byte,
    output logic [7:0]    tx_byte,
    output logic          reg_wr_en,
    output logic [AW-1:0] reg_addr,
    output logic [31:0]   reg_wr_data,
    input  logic [31:0]   reg_rd_data,
    output logic          cmd_err
);

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] CMD     = ST_CMD;
    localparam logic [2:0] WDATA   = ST_WDATA;
    localparam logic [2:0] RDATA   = ST_RDATA;
    localparam logic [2:0] DISCARD = ST_DISCARD;

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [2:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] rd_tail;     // read bytes still to be sent after the MSB
    logic        rd_pending;  // reg_addr settled last cycle, latch read data now
    logic        wait_low;    // blocks frame start until ssel_active drops once
    logic        last_byte;
    logic        cmd_addr_bad;

    assign last_byte    = (byte_cnt == LAST_BYTE);
    assign cmd_addr_bad = int'(rx_byte[ADDR_MSB:0]) >= NREGS;

`ifdef SPI_CMD_AUTOINC_EN
    logic inc_bad;
    assign inc_bad = (int'(reg_addr) + 1) >= NREGS;
`endif

    // NOTE: all state updates are non-blocking so every register sees the
    // pre-edge values; the reset is synchronous and therefore lives inside
    // the clocked block rather than in its sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            rd_tail     <= 24'd0;
            rd_pending  <= 1'b0;
            wait_low    <= 1'b1;
            tx_byte     <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= 32'd0;
            cmd_err     <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            rd_pending <= 1'b0;

            if (!ssel_active) begin
                // Frame ended (or never started): drop everything, including a
                // byte strobe arriving on this same cycle.
                state    <= IDLE;
                wait_low <= 1'b0;
                tx_byte  <= 8'h00;
            end else begin
                case (state)
                    IDLE: begin
                        if (!wait_low) begin
                            state    <= CMD;
                            byte_cnt <= 2'd0;
                            cmd_err  <= 1'b0;
                        end
                    end

                    CMD: begin
                        if (rx_valid) begin
                            reg_addr <= AW'(rx_byte[ADDR_MSB:0]);
                            byte_cnt <= 2'd0;
                            if (cmd_addr_bad) begin
                                cmd_err <= 1'b1;
                                state   <= DISCARD;
                            end else if (rx_byte[WR_BIT]) begin
                                state <= WDATA;
                            end else begin
                                state      <= RDATA;
                                rd_pending <= 1'b1;
                            end
                        end
                    end

                    WDATA: begin
                        if (rx_valid && !reg_wr_en) begin
                            reg_wr_data <= {reg_wr_data[23:0], rx_byte};
                            byte_cnt    <= byte_cnt + 2'd1;
                            reg_wr_en   <= last_byte;
                        end
                        // Step the address only after the strobe cycle so the
                        // bank sees the address the word was meant for.
                        if (reg_wr_en) begin
`ifdef SPI_CMD_AUTOINC_EN
                            if (inc_bad) begin
                                cmd_err <= 1'b1;
                                state   <= DISCARD;
                            end else begin
                                reg_addr <= reg_addr + AW'(1);
                            end
`else
                            state <= DISCARD;
`endif
                        end
                    end

                    RDATA: begin
                        if (rd_pending) begin
                            tx_byte <= reg_rd_data[31:24];
                            rd_tail <= reg_rd_data[23:0];
                        end else if (rx_valid) begin
                            tx_byte  <= rd_tail[23:16];
                            rd_tail  <= {rd_tail[15:0], 8'h00};
                            byte_cnt <= byte_cnt + 2'd1;
                            if (last_byte) begin
`ifdef SPI_CMD_AUTOINC_EN
                                if (inc_bad) begin
                                    cmd_err <= 1'b1;
                                    state   <= DISCARD;
                                end else begin
                                    reg_addr   <= reg_addr + AW'(1);
                                    rd_pending <= 1'b1;
                                end
`else
                                state <= DISCARD;
`endif
                                tx_byte <= 8'h00;
                            end
                        end
                    end

                    DISCARD: begin
                        tx_byte <= 8'h00;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_ctrl
// Self-checking bench for spi_cmd_ctrl with a behavioural register bank.
// Directed frames come from a table; random frames are checked against a
// frame-level reference model. Build with or without SPI_CMD_AUTOINC_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_cmd_ctrl;
    import spi_cmd_pkg::*;

    localparam int NREGS    = 8;
    localparam int AW       = 3;
    localparam int BYTE_GAP = 8;
`ifdef SPI_CMD_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          ssel_active;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_byte;
    logic          reg_wr_en;
    logic [AW-1:0] reg_addr;
    logic [31:0]   reg_wr_data;
    logic [31:0]   reg_rd_data;
    logic          cmd_err;

    always #5 clk = ~clk;

    spi_cmd_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ssel_active (ssel_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_byte     (tx_byte),
        .reg_wr_en   (reg_wr_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .cmd_err     (cmd_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    // Register bank and write log, fed by the DUT.
    logic [31:0] bank [NREGS];
    logic [31:0] init_vals [NREGS];
    logic        preload_en;
    wr_t         wr_q[$];

    assign reg_rd_data = bank[reg_addr];

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < NREGS; i++) bank[i] <= init_vals[i];
        end else if (reg_wr_en) begin
            bank[reg_addr] <= reg_wr_data;
            wr_q.push_back({reg_addr, reg_wr_data});
        end
    end

    // Per-frame observations and expectations.
    logic [7:0]  frame_q[$];
    logic [7:0]  tx_q[$];
    bit          wrp_q[$];
    int          wr_base;
    logic [31:0] model_regs [NREGS];
    logic [7:0]  exp_tx_q[$];
    bit          exp_wrp_q[$];
    wr_t         exp_wr_q[$];
    bit          exp_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        tx_q.push_back(tx_byte);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        wrp_q.push_back(reg_wr_en);
        repeat (BYTE_GAP - 1) @(negedge clk);
    endtask

    task automatic run_frame();
        tx_q.delete();
        wrp_q.delete();
        wr_base     = wr_q.size();
        ssel_active = 1'b1;
        repeat (3) @(negedge clk);
        foreach (frame_q[i]) send_byte(frame_q[i]);
    endtask

    task automatic end_frame();
        ssel_active = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Frame-level reference: what each data byte should see on tx_byte,
    // which bytes complete a write, and the final error flag.
    task automatic model_frame();
        int addr;
        int nd;
        bit wr;
        logic [7:0] c;
        exp_tx_q.delete();
        exp_wrp_q.delete();
        exp_wr_q.delete();
        c    = frame_q[0];
        addr = int'(c[6:0]);
        wr   = c[7];
        nd   = frame_q.size() - 1;
        exp_tx_q.push_back(8'h00);
        exp_wrp_q.push_back(1'b0);
        for (int j = 0; j < nd; j++) begin
            int w, k, cur;
            bit active, p;
            logic [7:0] t;
            logic [31:0] word;
            wr_t e;
            w = j / 4;
            k = j % 4;
            cur = addr + w;
            active = (cur < NREGS) && (AUTOINC || w == 0);
            t = 8'h00;
            p = 1'b0;
            if (active && !wr) t = model_regs[cur][31-8*k -: 8];
            if (active && wr && k == 3) begin
                word = {frame_q[j-2], frame_q[j-1], frame_q[j], frame_q[j+1]};
                model_regs[cur] = word;
                e.addr = AW'(cur);
                e.data = word;
                exp_wr_q.push_back(e);
                p = 1'b1;
            end
            exp_tx_q.push_back(t);
            exp_wrp_q.push_back(p);
        end
        exp_err = (addr >= NREGS) || (AUTOINC && nd >= 4 * (NREGS - addr));
    endtask

    task automatic compare_frame(input string tag);
        int nwr;
        foreach (exp_tx_q[i])
            check($sformatf("%s tx[%0d]", tag, i), 32'(tx_q[i]), 32'(exp_tx_q[i]));
        foreach (exp_wrp_q[i])
            check($sformatf("%s wr_pulse[%0d]", tag, i), 32'(wrp_q[i]), 32'(exp_wrp_q[i]));
        nwr = wr_q.size() - wr_base;
        check($sformatf("%s n_writes", tag), 32'(nwr), 32'(exp_wr_q.size()));
        foreach (exp_wr_q[i]) begin
            if (i < nwr) begin
                check($sformatf("%s wr%0d addr", tag, i), 32'(wr_q[wr_base+i].addr), 32'(exp_wr_q[i].addr));
                check($sformatf("%s wr%0d data", tag, i), wr_q[wr_base+i].data, exp_wr_q[i].data);
            end
        end
        check($sformatf("%s cmd_err", tag), 32'(cmd_err), 32'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_byte"},     32'(tx_byte),   32'h0);
        check({tag, " reg_wr_en"},   32'(reg_wr_en), 32'h0);
        check({tag, " reg_addr"},    32'(reg_addr),  32'h0);
        check({tag, " reg_wr_data"}, reg_wr_data,    32'h0);
        check({tag, " cmd_err"},     32'(cmd_err),   32'h0);
    endtask

    // Directed frames: bytes MSB-first in a 72-bit field, expected tx per byte likewise.
    typedef struct packed {
        logic [71:0]   bytes;
        logic [3:0]    nbytes;
        logic [1:0]    exp_nwr;
        logic [AW-1:0] exp_addr0;
        logic [31:0]   exp_data0;
        logic [AW-1:0] exp_addr1;
        logic [31:0]   exp_data1;
        logic [71:0]   exp_tx;
        logic          exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t cur;
        int   nwr;

        vecs[0] = '{72'h82DEADBEEF00000000, 4'd5, 2'd1, 3'd2, 32'hDEADBEEF, 3'd0, 32'h0,
                    72'h0, 1'b0};
        vecs[1] = '{72'h01AAAAAAAA00000000, 4'd5, 2'd0, 3'd0, 32'h0, 3'd0, 32'h0,
                    72'h001234567800000000, 1'b0};
        vecs[2] = '{72'h8ADEADBEEF00000000, 4'd5, 2'd0, 3'd0, 32'h0, 3'd0, 32'h0,
                    72'h0, 1'b1};
        vecs[3] = '{72'h831122000000000000, 4'd3, 2'd0, 3'd0, 32'h0, 3'd0, 32'h0,
                    72'h0, 1'b0};
`ifdef SPI_CMD_AUTOINC_EN
        vecs[4] = '{72'h861122334455667788, 4'd9, 2'd2, 3'd6, 32'h11223344, 3'd7, 32'h55667788,
                    72'h0, 1'b1};
`else
        vecs[4] = '{72'h861122334455667788, 4'd9, 2'd1, 3'd6, 32'h11223344, 3'd0, 32'h0,
                    72'h0, 1'b0};
`endif
        vecs[5] = '{72'h80CAFEF00D00000000, 4'd5, 2'd1, 3'd0, 32'hCAFEF00D, 3'd0, 32'h0,
                    72'h0, 1'b0};
        vecs[6] = '{72'h005555555500000000, 4'd5, 2'd0, 3'd0, 32'h0, 3'd0, 32'h0,
                    72'h00CAFEF00D00000000, 1'b0};

        for (int i = 0; i < NREGS; i++) init_vals[i] = $urandom;
        init_vals[1] = 32'h12345678;
        for (int i = 0; i < NREGS; i++) model_regs[i] = init_vals[i];

        reset       = 1'b1;
        preload_en  = 1'b1;
        ssel_active = 1'b0;
        rx_valid    = 1'b0;
        rx_byte     = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset      = 1'b0;
        preload_en = 1'b0;
        repeat (2) @(negedge clk);

        // Directed table.
        foreach (vecs[v]) begin
            cur = vecs[v];
            frame_q.delete();
            for (int i = 0; i < int'(cur.nbytes); i++) frame_q.push_back(cur.bytes[71-8*i -: 8]);
            model_frame();
            run_frame();
            for (int i = 0; i < int'(cur.nbytes); i++)
                check($sformatf("vec%0d tx[%0d]", v, i), 32'(tx_q[i]), 32'(cur.exp_tx[71-8*i -: 8]));
            nwr = wr_q.size() - wr_base;
            check($sformatf("vec%0d n_writes", v), 32'(nwr), 32'(cur.exp_nwr));
            if (cur.exp_nwr >= 2'd1 && nwr >= 1) begin
                check($sformatf("vec%0d wr0 addr", v), 32'(wr_q[wr_base].addr), 32'(cur.exp_addr0));
                check($sformatf("vec%0d wr0 data", v), wr_q[wr_base].data, cur.exp_data0);
            end
            if (cur.exp_nwr >= 2'd2 && nwr >= 2) begin
                check($sformatf("vec%0d wr1 addr", v), 32'(wr_q[wr_base+1].addr), 32'(cur.exp_addr1));
                check($sformatf("vec%0d wr1 data", v), wr_q[wr_base+1].data, cur.exp_data1);
            end
            if (cur.nbytes >= 4'd5)
                check($sformatf("vec%0d wr_pulse after 4th data byte", v), 32'(wrp_q[4]), 32'(cur.exp_nwr != 2'd0));
            check($sformatf("vec%0d cmd_err", v), 32'(cmd_err), 32'(cur.exp_err));
            end_frame();
        end

        // Bad address: flag is sticky past frame end, cleared at next frame start.
        frame_q.delete();
        frame_q.push_back(8'h8A);
        frame_q.push_back(8'h01);
        model_frame();
        run_frame();
        check("badaddr cmd_err in frame", 32'(cmd_err), 32'h1);
        end_frame();
        check("badaddr cmd_err after frame", 32'(cmd_err), 32'h1);
        ssel_active = 1'b1;
        repeat (2) @(negedge clk);
        check("badaddr cmd_err next frame", 32'(cmd_err), 32'h0);
        end_frame();

        // Short write frame: aborted, FSM back in IDLE.
        frame_q.delete();
        frame_q.push_back(8'h83);
        frame_q.push_back(8'h11);
        frame_q.push_back(8'h22);
        model_frame();
        run_frame();
        end_frame();
        check("short n_writes", 32'(wr_q.size() - wr_base), 32'h0);
        check("short state", 32'(dut.state), 32'(ST_IDLE));

        // Reset after the 3rd data byte, chip-select kept high throughout.
        frame_q.delete();
        frame_q.push_back(8'h85);
        frame_q.push_back(8'hA1);
        frame_q.push_back(8'hB2);
        frame_q.push_back(8'hC3);
        model_frame();
        run_frame();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        send_byte(8'hD4);
        send_byte(8'h81);
        for (int i = 0; i < 4; i++) send_byte(8'h5A);
        check("midreset n_writes", 32'(wr_q.size() - wr_base), 32'h0);
        check("midreset state", 32'(dut.state), 32'(ST_IDLE));
        check_reset_outputs("midreset held");
        end_frame();
        frame_q.delete();
        frame_q.push_back(8'h84);
        frame_q.push_back(8'h0F);
        frame_q.push_back(8'h1E);
        frame_q.push_back(8'h2D);
        frame_q.push_back(8'h3C);
        model_frame();
        run_frame();
        compare_frame("after_reset");
        end_frame();

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            int nd;
            frame_q.delete();
            frame_q.push_back({1'($urandom_range(0, 1)), 7'($urandom_range(0, 9))});
            nd = $urandom_range(0, 10);
            for (int j = 0; j < nd; j++) frame_q.push_back(8'($urandom));
            model_frame();
            run_frame();
            compare_frame($sformatf("rnd%0d", f));
            end_frame();
        end

        for (int i = 0; i < NREGS; i++)
            check($sformatf("bank[%0d]", i), bank[i], model_regs[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
